// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM, and a
// valid/ack output register with sticky overrun and one-cycle frame_err pulse.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic        sync1;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        dlv_pend;
  logic        ferr_pend;
  logic        ack_hit;
  logic        deliver;
  logic        drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rx_s  <= sync1;
    end
  end

  // Stop-sample results are held one cycle so delivery/frame_err land on the
  // cycle after the sample while the FSM is already back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      dlv_pend  <= 1'b0;
      ferr_pend <= 1'b0;
    end else begin
      dlv_pend  <= 1'b0;
      ferr_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
            cnt   <= HALF_RELOAD;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            state   <= DATA;
            cnt     <= FULL_RELOAD;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg[bit_idx] <= rx_s;
            cnt            <= FULL_RELOAD;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 16'd1;
          end else begin
            cnt <= '0;
            if (rx_s) begin
              state    <= IDLE;
              busy     <= 1'b0;
              dlv_pend <= 1'b1;
            end else begin
              state     <= BREAK;
              ferr_pend <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ack_hit = rx_ack && rx_valid;
    deliver = dlv_pend && (!rx_valid || rx_ack);
    drop    = dlv_pend && rx_valid && !rx_ack;
  end

  // A delivery on the ack cycle replaces the byte and keeps rx_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_pend;
      if (deliver) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (ack_hit) begin
        rx_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
      else if (ack_hit) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: directed scenarios plus random frames,
// glitches and broken stop bits checked against a frame-level expectation queue.
module tb_uart_rx_byte;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  logic [7:0]  exp_q[$];
  int          ferr_seen  = 0;
  bit          auto_ack   = 1'b0;
  bit          man_ack    = 1'b0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int unsigned n);
    rx_in = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(d[i], CPB);
    line(stop, CPB);
  endtask

  task automatic wait_neg(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic ack_once(input string tag);
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check({tag, "_valid_hold"}, rx_valid, 1);
    @(negedge clk);
    check({tag, "_valid_clear"}, rx_valid, 0);
  endtask

  // Consumer: random one-cycle acks in auto mode, otherwise follows man_ack.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (auto_ack) rx_ack = rx_valid && !rx_ack && ($urandom_range(0, 2) == 0);
      else rx_ack = man_ack;
    end
  end

  // Monitor: a new byte is presented when rx_valid rises or stays high across an ack.
  initial begin
    logic       prev_valid;
    logic       prev_ackv;
    logic [7:0] e;
    prev_valid = 1'b0;
    prev_ackv  = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid && (!prev_valid || prev_ackv)) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: got 0x%02h, expected no delivery", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e);
        end
      end
      if (frame_err) ferr_seen++;
      prev_valid = rx_valid;
      prev_ackv  = rx_ack && rx_valid;
    end
  end

  initial begin
    int unsigned e;
    int          f0;
    int          ferr_exp;
    int          busy_cnt;
    int          flag_cnt;
    int unsigned kind;
    logic [7:0]  d;

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    line(1'b1, 5);

    // 0xA5 with exact delivery latency and single-cycle ack
    f0 = ferr_seen;
    exp_q.push_back(8'hA5);
    e = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        wait_neg(e + 155);
        check("a5_valid_before", rx_valid, 0);
        wait_neg(e + 156);
        check("a5_valid_at", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_ferr", frame_err, 0);
      end
    join
    ack_once("a5");
    tick();
    check("a5_ferr_count", ferr_seen - f0, 0);

    // 4-cycle low glitch
    e = cyc;
    busy_cnt = 0;
    flag_cnt = 0;
    fork
      begin
        line(1'b0, 4);
        line(1'b1, 24);
      end
      begin
        for (int i = 0; i < 22; i++) begin
          @(negedge clk);
          if (busy) busy_cnt++;
          if (rx_valid || frame_err || overrun) flag_cnt++;
        end
      end
    join
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_flags", flag_cnt, 0);
    check("glitch_idle", busy, 0);

    // broken stop bit, held-low break, then a good byte
    auto_ack = 1'b1;
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0);
    line(1'b0, 40);
    line(1'b1, 20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    line(1'b1, 30);
    check("break_ferr_count", ferr_seen - f0, 1);
    check("break_q_drain", exp_q.size(), 0);

    // back-to-back with no ack: second byte dropped
    auto_ack = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    line(1'b1, 4);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    ack_once("ovr");
    check("ovr_cleared", overrun, 0);
    tick();

    // ack on the delivery cycle of a second byte
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    line(1'b1, 2);
    exp_q.push_back(8'h22);
    e = cyc;
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_neg(e + 154);
        man_ack = 1'b1;
        wait_neg(e + 155);
        man_ack = 1'b0;
        wait_neg(e + 156);
        check("ackdlv_data", rx_data, 8'h22);
        check("ackdlv_valid", rx_valid, 1);
        check("ackdlv_overrun", overrun, 0);
      end
    join
    line(1'b1, 4);

    // reset during data bit 4 of 0xFF, with 0x22 still pending
    e = cyc;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_neg(e + 85);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        wait_neg(e + 88);
        rst = 1'b0;
      end
    join
    line(1'b1, 10);
    check("midrst_no_byte", rx_valid, 0);
    auto_ack = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    line(1'b1, 30);
    check("midrst_q_drain", exp_q.size(), 0);

    // random frames, glitches and framing errors
    f0 = ferr_seen;
    ferr_exp = 0;
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 7);
      d = 8'($urandom);
      if (kind == 0) begin
        line(1'b0, $urandom_range(1, 6));
        line(1'b1, 14);
      end else if (kind == 1) begin
        ferr_exp++;
        send_frame(d, 1'b0);
        line(1'b0, $urandom_range(0, 30));
        line(1'b1, $urandom_range(3, 10));
      end else begin
        exp_q.push_back(d);
        send_frame(d, 1'b1);
        line(1'b1, $urandom_range(0, 10));
      end
    end
    line(1'b1, 40);
    check("rand_q_drain", exp_q.size(), 0);
    check("rand_ferr_count", ferr_seen - f0, ferr_exp);
    check("rand_overrun", overrun, 0);
    check("rand_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial receiver that turns the 8N1 stream on one dedicated input pin into parallel bytes for the project core. It is the input stage in front of the top-level arithmetic datapath: each received byte is held in an output register with a valid/ack handshake, so the consumer can take it at its own pace. Frame and overrun errors are reported as status.

## Interface
- CLKS_PER_BIT, 104, clock cycles per serial bit; legal range 8..65535, and must be even.
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  raw serial line, asynchronous to clk, idles high.
- rx_ack  input  1  consumer acknowledge; sampled only while rx_valid=1.
- rx_data  output  8  last delivered byte, LSB received first.
- rx_valid  output  1  high while rx_data holds an unacknowledged byte.
- frame_err  output  1  one-cycle pulse when a stop bit samples low.
- overrun  output  1  sticky: a complete byte was dropped because rx_valid was still set.
- busy  output  1  high in every state except IDLE.

## Operation
- Input path: two-flop synchronizer. Both flops reset to 1. rx_s is the output of the second flop.
- Bit-timing counter: 16 bits wide; it reloads on every state entry.
- State machine:
  - IDLE: if rx_s=0, go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 1 (glitch), go to IDLE with no output. If 0, go to DATA with bit index 0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index]. After index 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: deliver the byte, then go to IDLE.
    - If 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Delivery, on the cycle after the stop sample:
  - If rx_valid=0, or rx_ack=1 on that same cycle: load rx_data and set rx_valid=1.
  - Otherwise: rx_data is unchanged and overrun is set to 1.
- Handshake: rx_ack=1 while rx_valid=1 clears rx_valid on the next edge, unless a delivery occurs on that same edge. In that case rx_valid stays 1, rx_data takes the new byte, and overrun is not set.
- overrun clears only on rst, or on a cycle where rx_ack=1 and rx_valid=1. If that clearing cycle coincides with a dropped delivery, set wins.
- rx_ack while rx_valid=0 is ignored.
- Reset values: state IDLE, rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, counter=0, shift register=0.
- Reset mid-frame: the partial byte is lost. After release, the receiver waits for a fresh falling edge in IDLE.

## Timing
- T0 = first clk edge at which the FSM is in IDLE and sees rx_s=0. The pin-to-rx_s latency is 2 cycles.
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit n (n=0..7) sample: T0 + CLKS_PER_BIT/2 + (n+1)*CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- rx_valid rises, or frame_err pulses, 1 cycle after the stop sample.
- The FSM is back in IDLE on that same cycle. A start bit immediately following a half-length stop bit is therefore still caught.
- rx_valid falls 1 cycle after the rx_ack edge.
- All outputs are registered. No combinational path from rx_in or rx_ack to any output.
- Tolerates ±4% baud mismatch at CLKS_PER_BIT ≥ 16.

## Test plan
- CLKS_PER_BIT=16. Send 0xA5 as 8N1. Required: rx_data=0xA5 and rx_valid=1 exactly at stop-sample+1; frame_err=0; then assert rx_ack for 1 cycle and require rx_valid=0 on the next cycle.
- Low glitch of 4 cycles on rx_in from idle. Required: the FSM returns to IDLE after the start sample; rx_valid, frame_err and overrun all stay 0; busy is high for exactly 8 cycles.
- Send 0x3C with the stop bit forced low, then hold the line low for 40 cycles, then release high, then send 0x81. Required: exactly one frame_err pulse; no rx_valid for 0x3C; rx_data=0x81 is delivered.
- Send 0x11 and 0x22 back-to-back with no rx_ack. Required: rx_data=0x11, rx_valid=1, overrun=1 after the second stop. Then rx_ack → overrun=0 and rx_valid=0.
- Hold rx_ack=1 on the delivery cycle of a second byte 0x22, with 0x11 pending. Required: rx_data=0x22, rx_valid stays 1, overrun=0.
- Assert rst during data bit 4 of 0xFF, release, then send 0x5A. Required: all outputs at reset values immediately on rst (async); no byte delivered for 0xFF; rx_data=0x5A is delivered.
